// File: rtl/tx_huge_page_rd_req_pkg.sv
// Shared constants, state encoding and header payload for the TX huge-page read requester.
package tx_huge_page_rd_req_pkg;

  localparam logic [7:0] MEM_RD32_FMT_TYPE = 8'h00;
  localparam logic [7:0] MEM_RD64_FMT_TYPE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_HDR1,
    ST_HDR2,
    ST_DRAIN,
    ST_FREE,
    ST_WAIT_CLR
  } rd_state_e;

  typedef struct packed {
    logic [7:0] fmt_type;
    logic       rsvd0;
    logic [2:0] tc;
    logic [3:0] rsvd1;
    logic       td;
    logic       ep;
    logic [1:0] attr;
    logic [1:0] rsvd2;
    logic [9:0] length;
  } tlp_dw0_t;

  // Memory-read DW0 with TC/attr zero; a 1024 DW length naturally encodes as 0.
  function automatic logic [31:0] mrd_dw0(input logic [7:0] fmt_type, input logic [9:0] len_dw);
    tlp_dw0_t h;
    h          = '0;
    h.fmt_type = fmt_type;
    h.length   = len_dw;
    return h;
  endfunction

endpackage

// File: rtl/tx_huge_page_rd_req_tag_credit.sv
// tx_rd_tag_credit: outstanding-read counter, next-tag counter and credit-available flag.
module tx_rd_tag_credit
  import tx_huge_page_rd_req_pkg::*;
#(
  parameter int unsigned TAG_W           = 5,
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             tag_release,
  output logic [TAG_W-1:0] cur_tag,
  output logic             credit_ok_c,
  output logic             drained_c
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;

  // Simultaneous issue and release cancel; a release with nothing in flight is dropped.
  always_comb begin
    outstanding_d = outstanding_q;
    cur_tag_d     = cur_tag_q;
    if (issue) begin
      cur_tag_d = cur_tag_q + TAG_W'(1);
    end
    if (issue && !tag_release) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!issue && tag_release && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      cur_tag_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      cur_tag_q     <= cur_tag_d;
    end
  end

  assign cur_tag     = cur_tag_q;
  assign credit_ok_c = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  assign drained_c   = (outstanding_q == '0);

endmodule

// File: rtl/tx_huge_page_rd_req.sv
// Walks the two huge pages ping-pong, issues MRd TLPs on TRN TX and frees each page once drained.
// Optional TX_RD_REQ_MRD32_EN: use 3-DW MRd32 headers when the upper address dword is zero.
module tx_huge_page_rd_req
  import tx_huge_page_rd_req_pkg::*;
#(
  parameter int unsigned MAX_RD_QW       = 64,
  parameter int unsigned TAG_W           = 5,
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic [63:0]      huge_page_addr_1,
  input  logic [63:0]      huge_page_addr_2,
  input  logic [31:0]      huge_page_qwords_1,
  input  logic [31:0]      huge_page_qwords_2,
  input  logic             huge_page_status_1,
  input  logic             huge_page_status_2,
  output logic             huge_page_free_1,
  output logic             huge_page_free_2,
  input  logic [15:0]      cfg_completer_id,
  input  logic             tag_release,
  output logic             tx_req,
  input  logic             tx_gnt,
  output logic [63:0]      trn_td,
  output logic [7:0]       trn_trem_n,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_tsrc_rdy_n,
  input  logic             trn_tdst_rdy_n,
  output logic [TAG_W-1:0] cur_tag
);

  rd_state_e   state_q, state_d;
  logic        page_q, page_d;
  logic [63:0] rd_addr_q, rd_addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic        tx_req_q, tx_req_d;
  logic [63:0] td_q, td_d;
  logic [7:0]  trem_n_q, trem_n_d;
  logic        tsof_n_q, tsof_n_d;
  logic        teof_n_q, teof_n_d;
  logic        src_rdy_n_q, src_rdy_n_d;
  logic        free_1_q, free_1_d;
  logic        free_2_q, free_2_d;

  logic        status_sel_c;
  logic [63:0] addr_sel_c;
  logic [31:0] qwords_sel_c;
  logic [31:0] chunk_c;
  logic        use32_c;
  logic [63:0] beat1_c, beat2_c;
  logic [7:0]  trem2_n_c;
  logic        issue_c, credit_ok_c, drained_c;

  assign status_sel_c = page_q ? huge_page_status_2 : huge_page_status_1;
  assign addr_sel_c   = page_q ? huge_page_addr_2   : huge_page_addr_1;
  assign qwords_sel_c = page_q ? huge_page_qwords_2 : huge_page_qwords_1;
  assign chunk_c      = (remaining_q > 32'(MAX_RD_QW)) ? 32'(MAX_RD_QW) : remaining_q;
  assign issue_c      = (state_q == ST_HDR2) && !trn_tdst_rdy_n;

`ifdef TX_RD_REQ_MRD32_EN
  assign use32_c = (rd_addr_q[63:32] == 32'h0);
`else
  assign use32_c = 1'b0;
`endif

  assign beat1_c   = {mrd_dw0(use32_c ? MEM_RD32_FMT_TYPE : MEM_RD64_FMT_TYPE, 10'(chunk_c << 1)),
                      cfg_completer_id, 8'(cur_tag), 4'hF, 4'hF};
  assign beat2_c   = use32_c ? {rd_addr_q[31:2], 2'b00, 32'h0}
                             : {rd_addr_q[63:32], rd_addr_q[31:2], 2'b00};
  assign trem2_n_c = use32_c ? 8'h0F : 8'h00;

  tx_rd_tag_credit #(
    .TAG_W           (TAG_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk         (trn_clk),
    .rst         (reset),
    .issue       (issue_c),
    .tag_release (tag_release),
    .cur_tag     (cur_tag),
    .credit_ok_c (credit_ok_c),
    .drained_c   (drained_c)
  );

  // Next-state and registered-output values; every output flop holds unless changed here.
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    tx_req_d    = tx_req_q;
    td_d        = td_q;
    trem_n_d    = trem_n_q;
    tsof_n_d    = tsof_n_q;
    teof_n_d    = teof_n_q;
    src_rdy_n_d = src_rdy_n_q;
    free_1_d    = 1'b0;
    free_2_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (status_sel_c) begin
          rd_addr_d   = addr_sel_c;
          remaining_d = qwords_sel_c;
          if (qwords_sel_c == 32'h0) begin
            state_d = ST_FREE;
          end else begin
            state_d  = ST_ARB;
            tx_req_d = credit_ok_c;
          end
        end
      end
      ST_ARB: begin
        if (!tx_req_q) begin
          tx_req_d = credit_ok_c;
        end else if (tx_gnt) begin
          state_d     = ST_HDR1;
          td_d        = beat1_c;
          trem_n_d    = 8'h00;
          tsof_n_d    = 1'b0;
          src_rdy_n_d = 1'b0;
        end
      end
      ST_HDR1: begin
        if (!trn_tdst_rdy_n) begin
          state_d  = ST_HDR2;
          td_d     = beat2_c;
          trem_n_d = trem2_n_c;
          tsof_n_d = 1'b1;
          teof_n_d = 1'b0;
        end
      end
      ST_HDR2: begin
        if (!trn_tdst_rdy_n) begin
          rd_addr_d   = rd_addr_q + 64'({chunk_c, 3'b000});
          remaining_d = remaining_q - chunk_c;
          tx_req_d    = 1'b0;
          td_d        = 64'h0;
          trem_n_d    = 8'hFF;
          teof_n_d    = 1'b1;
          src_rdy_n_d = 1'b1;
          state_d     = (remaining_q == chunk_c) ? ST_DRAIN : ST_ARB;
        end
      end
      ST_DRAIN: begin
        if (drained_c) begin
          state_d = ST_FREE;
        end
      end
      ST_FREE: begin
        free_1_d = !page_q;
        free_2_d = page_q;
        state_d  = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!status_sel_c) begin
          page_d  = !page_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      page_q      <= 1'b0;
      rd_addr_q   <= 64'h0;
      remaining_q <= 32'h0;
      tx_req_q    <= 1'b0;
      td_q        <= 64'h0;
      trem_n_q    <= 8'hFF;
      tsof_n_q    <= 1'b1;
      teof_n_q    <= 1'b1;
      src_rdy_n_q <= 1'b1;
      free_1_q    <= 1'b0;
      free_2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      tx_req_q    <= tx_req_d;
      td_q        <= td_d;
      trem_n_q    <= trem_n_d;
      tsof_n_q    <= tsof_n_d;
      teof_n_q    <= teof_n_d;
      src_rdy_n_q <= src_rdy_n_d;
      free_1_q    <= free_1_d;
      free_2_q    <= free_2_d;
    end
  end

  assign tx_req           = tx_req_q;
  assign trn_td           = td_q;
  assign trn_trem_n       = trem_n_q;
  assign trn_tsof_n       = tsof_n_q;
  assign trn_teof_n       = teof_n_q;
  assign trn_tsrc_rdy_n   = src_rdy_n_q;
  assign huge_page_free_1 = free_1_q;
  assign huge_page_free_2 = free_2_q;

endmodule

// File: tb/tb_tx_huge_page_rd_req.sv
// Directed self-checking bench for tx_huge_page_rd_req (MAX_RD_QW=64, MAX_OUTSTANDING=2).
module tb_tx_huge_page_rd_req;

  logic        trn_clk;
  logic        reset;
  logic [63:0] huge_page_addr_1, huge_page_addr_2;
  logic [31:0] huge_page_qwords_1, huge_page_qwords_2;
  logic        huge_page_status_1, huge_page_status_2;
  logic        huge_page_free_1, huge_page_free_2;
  logic [15:0] cfg_completer_id;
  logic        tag_release;
  logic        tx_req;
  logic        tx_gnt;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic [4:0]  cur_tag;

  int n_cmp  = 0;
  int n_fail = 0;

  int          tlp_cnt   = 0;
  int          free1_cnt = 0;
  int          free2_cnt = 0;
  logic [63:0] mon_b1 [64];
  logic [63:0] mon_b2 [64];
  logic [7:0]  mon_trem [64];
  logic [63:0] cap_b1;

  tx_huge_page_rd_req #(
    .MAX_RD_QW       (64),
    .TAG_W           (5),
    .MAX_OUTSTANDING (2)
  ) dut (
    .trn_clk            (trn_clk),
    .reset              (reset),
    .huge_page_addr_1   (huge_page_addr_1),
    .huge_page_addr_2   (huge_page_addr_2),
    .huge_page_qwords_1 (huge_page_qwords_1),
    .huge_page_qwords_2 (huge_page_qwords_2),
    .huge_page_status_1 (huge_page_status_1),
    .huge_page_status_2 (huge_page_status_2),
    .huge_page_free_1   (huge_page_free_1),
    .huge_page_free_2   (huge_page_free_2),
    .cfg_completer_id   (cfg_completer_id),
    .tag_release        (tag_release),
    .tx_req             (tx_req),
    .tx_gnt             (tx_gnt),
    .trn_td             (trn_td),
    .trn_trem_n         (trn_trem_n),
    .trn_tsof_n         (trn_tsof_n),
    .trn_teof_n         (trn_teof_n),
    .trn_tsrc_rdy_n     (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n     (trn_tdst_rdy_n),
    .cur_tag            (cur_tag)
  );

  // Arbiter model: grants immediately and holds while requested.
  assign tx_gnt = tx_req;

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  // Capture accepted TLP beats and free pulses on the falling edge.
  always @(negedge trn_clk) begin
    if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      if (!trn_tsof_n) cap_b1 = trn_td;
      if (!trn_teof_n) begin
        if (tlp_cnt < 64) begin
          mon_b1[tlp_cnt]   = cap_b1;
          mon_b2[tlp_cnt]   = trn_td;
          mon_trem[tlp_cnt] = trn_trem_n;
        end
        tlp_cnt = tlp_cnt + 1;
      end
    end
    if (huge_page_free_1) free1_cnt = free1_cnt + 1;
    if (huge_page_free_2) free2_cnt = free2_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge trn_clk);
    #1;
  endtask

  task automatic pulse_release();
    tag_release = 1'b1;
    tick(1);
    tag_release = 1'b0;
  endtask

  task automatic wait_tlp(input int target, output bit to);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (tlp_cnt >= target) begin
        to = 1'b0;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_free(input int which, input int target, output bit to);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (((which == 1) ? free1_cnt : free2_cnt) >= target) begin
        to = 1'b0;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_sof(output bit to);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge trn_clk);
      if (!trn_tsof_n && !trn_tsrc_rdy_n) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_cmp++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    n_cmp++; if (trn_tsof_n !== 1'b1) begin n_fail++; $display("FAIL reset_tsof_n: got %b want 1", trn_tsof_n); end
    n_cmp++; if (trn_teof_n !== 1'b1) begin n_fail++; $display("FAIL reset_teof_n: got %b want 1", trn_teof_n); end
    n_cmp++; if (trn_tsrc_rdy_n !== 1'b1) begin n_fail++; $display("FAIL reset_src_rdy_n: got %b want 1", trn_tsrc_rdy_n); end
    n_cmp++; if (trn_td !== 64'h0) begin n_fail++; $display("FAIL reset_td: got %h want 0", trn_td); end
    n_cmp++; if (trn_trem_n !== 8'hFF) begin n_fail++; $display("FAIL reset_trem_n: got %h want ff", trn_trem_n); end
    n_cmp++; if ({huge_page_free_1, huge_page_free_2} !== 2'b00) begin n_fail++; $display("FAIL reset_free: got %b want 00", {huge_page_free_1, huge_page_free_2}); end
    n_cmp++; if (cur_tag !== 5'd0) begin n_fail++; $display("FAIL reset_cur_tag: got %0d want 0", cur_tag); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_multi_req();
    logic [63:0] exp_b1 [4];
    logic [63:0] exp_b2 [4];
    int base, f1b;
    bit to;
    exp_b1 = '{64'h2000_0080_BEEF_00FF, 64'h2000_0080_BEEF_01FF,
               64'h2000_0080_BEEF_02FF, 64'h2000_0010_BEEF_03FF};
    exp_b2 = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0200,
               64'h0000_0001_0000_0400, 64'h0000_0001_0000_0600};
    base = tlp_cnt;
    f1b  = free1_cnt;
    huge_page_addr_1   = 64'h0000_0001_0000_0000;
    huge_page_qwords_1 = 32'd200;
    huge_page_status_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tlp(base + k + 1, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL multi_tlp_timeout: got %0d tlps want %0d", tlp_cnt - base, k + 1); end
      if (k < 3) pulse_release();
    end
    tick(6);
    n_cmp++; if (free1_cnt !== f1b) begin n_fail++; $display("FAIL multi_early_free: got %0d pulses want 0", free1_cnt - f1b); end
    pulse_release();
    wait_free(1, f1b + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL multi_free_timeout: got 0 pulses want 1"); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mon_b1[base + k] !== exp_b1[k]) begin n_fail++; $display("FAIL multi_beat1[%0d]: got %h want %h", k, mon_b1[base + k], exp_b1[k]); end
      n_cmp++; if (mon_b2[base + k] !== exp_b2[k]) begin n_fail++; $display("FAIL multi_beat2[%0d]: got %h want %h", k, mon_b2[base + k], exp_b2[k]); end
      n_cmp++; if (mon_trem[base + k] !== 8'h00) begin n_fail++; $display("FAIL multi_trem[%0d]: got %h want 00", k, mon_trem[base + k]); end
    end
    huge_page_status_1 = 1'b0;
    tick(4);
    n_cmp++; if (free1_cnt !== f1b + 1) begin n_fail++; $display("FAIL multi_free_count: got %0d want 1", free1_cnt - f1b); end
    n_cmp++; if (tlp_cnt !== base + 4) begin n_fail++; $display("FAIL multi_tlp_count: got %0d want 4", tlp_cnt - base); end
  endtask

  task automatic test_credit_limit();
    int base, f2b;
    bit to, req_seen;
    base = tlp_cnt;
    f2b  = free2_cnt;
    huge_page_addr_2   = 64'h0000_0002_0000_0000;
    huge_page_qwords_2 = 32'd256;
    huge_page_status_2 = 1'b1;
    wait_tlp(base + 2, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL credit_first_two_timeout: got %0d tlps want 2", tlp_cnt - base); end
    tick(2);
    req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_req !== 1'b0) req_seen = 1'b1;
      tick(1);
    end
    n_cmp++; if (req_seen !== 1'b0) begin n_fail++; $display("FAIL credit_req_blocked: got tx_req high want low"); end
    n_cmp++; if (tlp_cnt !== base + 2) begin n_fail++; $display("FAIL credit_stall_count: got %0d tlps want 2", tlp_cnt - base); end
    pulse_release();
    wait_tlp(base + 3, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL credit_third_timeout: got %0d tlps want 3", tlp_cnt - base); end
    n_cmp++; if (mon_b1[base + 2] !== 64'h2000_0080_BEEF_06FF) begin n_fail++; $display("FAIL credit_third_beat1: got %h want 20000080beef06ff", mon_b1[base + 2]); end
    n_cmp++; if (mon_b2[base + 2] !== 64'h0000_0002_0000_0400) begin n_fail++; $display("FAIL credit_third_beat2: got %h want 0000000200000400", mon_b2[base + 2]); end
    pulse_release();
    wait_tlp(base + 4, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL credit_fourth_timeout: got %0d tlps want 4", tlp_cnt - base); end
    pulse_release();
    tick(1);
    pulse_release();
    wait_free(2, f2b + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL credit_free_timeout: got 0 pulses want 1"); end
    huge_page_status_2 = 1'b0;
    tick(4);
  endtask

  task automatic test_zero_qwords();
    int base, f2b;
    bit to, got;
    base = tlp_cnt;
    f2b  = free2_cnt;
    huge_page_addr_2   = 64'h0000_0004_0000_0000;
    huge_page_qwords_2 = 32'd16;
    huge_page_status_2 = 1'b1;
    huge_page_addr_1   = 64'h0000_0008_0000_0000;
    huge_page_qwords_1 = 32'd0;
    huge_page_status_1 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge trn_clk);
      if (huge_page_free_1) got = 1'b1;
    end
    n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL zero_free_latency: got no pulse want pulse within 3 cycles"); end
    tick(6);
    n_cmp++; if (tlp_cnt !== base) begin n_fail++; $display("FAIL zero_no_tlp: got %0d tlps want 0", tlp_cnt - base); end
    huge_page_status_1 = 1'b0;
    wait_tlp(base + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL zero_page2_timeout: got 0 tlps want 1"); end
    n_cmp++; if (mon_b1[base] !== 64'h2000_0020_BEEF_08FF) begin n_fail++; $display("FAIL zero_page2_beat1: got %h want 20000020beef08ff", mon_b1[base]); end
    n_cmp++; if (mon_b2[base] !== 64'h0000_0004_0000_0000) begin n_fail++; $display("FAIL zero_page2_beat2: got %h want 0000000400000000", mon_b2[base]); end
    pulse_release();
    wait_free(2, f2b + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL zero_page2_free_timeout: got 0 pulses want 1"); end
    huge_page_status_2 = 1'b0;
    tick(4);
  endtask

  task automatic test_hold_beat2();
    int base, f1b;
    bit to, stable;
    base = tlp_cnt;
    f1b  = free1_cnt;
    trn_tdst_rdy_n     = 1'b1;
    huge_page_addr_1   = 64'h0000_0003_0000_1000;
    huge_page_qwords_1 = 32'd8;
    huge_page_status_1 = 1'b1;
    wait_sof(to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL hold_sof_timeout: got no sof want sof"); end
    @(posedge trn_clk); #1;
    trn_tdst_rdy_n = 1'b0;
    @(posedge trn_clk); #1;
    trn_tdst_rdy_n = 1'b1;
    n_cmp++; if (cur_tag !== 5'd9) begin n_fail++; $display("FAIL hold_tag_before: got %0d want 9", cur_tag); end
    stable = 1'b1;
    repeat (5) begin
      @(negedge trn_clk);
      if (trn_td !== 64'h0000_0003_0000_1000 || trn_teof_n !== 1'b0 || trn_tsrc_rdy_n !== 1'b0) stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_beat2_stable: got td=%h teof_n=%b want 0000000300001000/0", trn_td, trn_teof_n); end
    @(posedge trn_clk); #1;
    n_cmp++; if (tlp_cnt !== base) begin n_fail++; $display("FAIL hold_not_accepted: got %0d tlps want 0", tlp_cnt - base); end
    trn_tdst_rdy_n = 1'b0;
    tick(5);
    n_cmp++; if (tlp_cnt !== base + 1) begin n_fail++; $display("FAIL hold_tlp_count: got %0d want 1", tlp_cnt - base); end
    n_cmp++; if (cur_tag !== 5'd10) begin n_fail++; $display("FAIL hold_tag_after: got %0d want 10", cur_tag); end
    n_cmp++; if (mon_b1[base] !== 64'h2000_0010_BEEF_09FF) begin n_fail++; $display("FAIL hold_beat1: got %h want 20000010beef09ff", mon_b1[base]); end
    pulse_release();
    wait_free(1, f1b + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL hold_free_timeout: got 0 pulses want 1"); end
    huge_page_status_1 = 1'b0;
    tick(4);
  endtask

  task automatic test_coincident_release();
    int base, f2b;
    bit to;
    base = tlp_cnt;
    f2b  = free2_cnt;
    trn_tdst_rdy_n     = 1'b0;
    huge_page_addr_2   = 64'h0000_0005_0000_0000;
    huge_page_qwords_2 = 32'd128;
    huge_page_status_2 = 1'b1;
    wait_tlp(base + 1, to);
    trn_tdst_rdy_n = 1'b1;
    n_cmp++; if (to) begin n_fail++; $display("FAIL coinc_first_timeout: got 0 tlps want 1"); end
    wait_sof(to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL coinc_sof_timeout: got no sof want sof"); end
    @(posedge trn_clk); #1;
    trn_tdst_rdy_n = 1'b0;
    @(posedge trn_clk); #1;
    trn_tdst_rdy_n = 1'b1;
    tick(2);
    trn_tdst_rdy_n = 1'b0;
    tag_release    = 1'b1;
    tick(1);
    tag_release    = 1'b0;
    tick(10);
    n_cmp++; if (tlp_cnt !== base + 2) begin n_fail++; $display("FAIL coinc_tlp_count: got %0d want 2", tlp_cnt - base); end
    n_cmp++; if (free2_cnt !== f2b) begin n_fail++; $display("FAIL coinc_outstanding_one: got early free want none"); end
    pulse_release();
    wait_free(2, f2b + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL coinc_free_timeout: got 0 pulses want 1"); end
    huge_page_status_2 = 1'b0;
    tick(4);
  endtask

  task automatic test_mrd_format();
    int base, f1b;
    bit to;
    logic [63:0] exp_b1, exp_b2;
    logic [7:0]  exp_trem;
`ifdef TX_RD_REQ_MRD32_EN
    exp_b1   = 64'h0000_0010_BEEF_0CFF;
    exp_b2   = 64'h0020_0000_0000_0000;
    exp_trem = 8'h0F;
`else
    exp_b1   = 64'h2000_0010_BEEF_0CFF;
    exp_b2   = 64'h0000_0000_0020_0000;
    exp_trem = 8'h00;
`endif
    base = tlp_cnt;
    f1b  = free1_cnt;
    huge_page_addr_1   = 64'h0000_0000_0020_0000;
    huge_page_qwords_1 = 32'd8;
    huge_page_status_1 = 1'b1;
    wait_tlp(base + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL fmt_timeout: got 0 tlps want 1"); end
    n_cmp++; if (mon_b1[base] !== exp_b1) begin n_fail++; $display("FAIL fmt_beat1: got %h want %h", mon_b1[base], exp_b1); end
    n_cmp++; if (mon_b2[base] !== exp_b2) begin n_fail++; $display("FAIL fmt_beat2: got %h want %h", mon_b2[base], exp_b2); end
    n_cmp++; if (mon_trem[base] !== exp_trem) begin n_fail++; $display("FAIL fmt_trem: got %h want %h", mon_trem[base], exp_trem); end
    pulse_release();
    wait_free(1, f1b + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL fmt_free_timeout: got 0 pulses want 1"); end
    huge_page_status_1 = 1'b0;
    tick(4);
  endtask

  task automatic test_async_reset();
    int base, f1b;
    bit to;
    base = tlp_cnt;
    trn_tdst_rdy_n     = 1'b1;
    huge_page_addr_2   = 64'h0000_0006_0000_0000;
    huge_page_qwords_2 = 32'd8;
    huge_page_status_2 = 1'b1;
    wait_sof(to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL areset_sof_timeout: got no sof want sof"); end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (trn_tsrc_rdy_n !== 1'b1) begin n_fail++; $display("FAIL areset_src_rdy_n: got %b want 1", trn_tsrc_rdy_n); end
    n_cmp++; if (trn_tsof_n !== 1'b1) begin n_fail++; $display("FAIL areset_tsof_n: got %b want 1", trn_tsof_n); end
    n_cmp++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL areset_tx_req: got %b want 0", tx_req); end
    n_cmp++; if (cur_tag !== 5'd0) begin n_fail++; $display("FAIL areset_cur_tag: got %0d want 0", cur_tag); end
    huge_page_status_2 = 1'b0;
    trn_tdst_rdy_n     = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    f1b = free1_cnt;
    huge_page_addr_1   = 64'h0000_0007_0000_0000;
    huge_page_qwords_1 = 32'd8;
    huge_page_status_1 = 1'b1;
    wait_tlp(base + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL areset_page1_timeout: got 0 tlps want 1"); end
    n_cmp++; if (mon_b1[base] !== 64'h2000_0010_BEEF_00FF) begin n_fail++; $display("FAIL areset_page1_beat1: got %h want 20000010beef00ff", mon_b1[base]); end
    n_cmp++; if (mon_b2[base] !== 64'h0000_0007_0000_0000) begin n_fail++; $display("FAIL areset_page1_beat2: got %h want 0000000700000000", mon_b2[base]); end
    pulse_release();
    wait_free(1, f1b + 1, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL areset_free_timeout: got 0 pulses want 1"); end
    huge_page_status_1 = 1'b0;
    tick(4);
  endtask

  initial begin
    reset              = 1'b1;
    huge_page_addr_1   = 64'h0;
    huge_page_addr_2   = 64'h0;
    huge_page_qwords_1 = 32'h0;
    huge_page_qwords_2 = 32'h0;
    huge_page_status_1 = 1'b0;
    huge_page_status_2 = 1'b0;
    cfg_completer_id   = 16'hBEEF;
    tag_release        = 1'b0;
    trn_tdst_rdy_n     = 1'b0;

    test_reset();
    test_multi_req();
    test_credit_limit();
    test_zero_qwords();
    test_hold_beat2();
    test_coincident_release();
    test_mrd_format();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
